// File: rtl/rv_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM states.
package rv_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } rsp_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte-enables/replicated write data and
// load extraction with sign/zero extension. Flags illegal size and misalignment.
module load_store_align
   import rv_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   input  logic        i_unsigned,
   output logic [3:0]  o_be,
   output logic [31:0] o_wlane,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be    = 4'b0000;
      o_wlane = 32'h0;
      o_rdata = 32'h0;
      o_err   = 1'b0;
      w_byte  = i_rword[8*i_addr_lo +: 8];
      w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
      case (mem_size_t'(i_size))
         MEM_BYTE: begin
            // Data is replicated across all lanes; the enable picks the one that lands.
            o_be    = 4'b0001 << i_addr_lo;
            o_wlane = {4{i_wdata[7:0]}};
            o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         MEM_HALF: begin
            o_err   = i_addr_lo[0];
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wlane = {2{i_wdata[15:0]}};
            o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         MEM_WORD: begin
            o_err   = (i_addr_lo != 2'b00);
            o_be    = 4'b1111;
            o_wlane = i_wdata;
            o_rdata = i_rword;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with word storage, fixed response
// latency of WAIT_CYCLES+1 and ready/valid handshakes on both sides.
module data_mem_responder
   import rv_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   rsp_state_t  r_state, w_next;
   logic [3:0]  r_cnt;
   logic        r_write, r_unsigned;
   logic [31:0] r_addr, r_wdata;
   logic [1:0]  r_size;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_error;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept, w_fire, w_idle;
   logic        w_op_write, w_op_unsigned;
   logic [31:0] w_op_addr, w_op_wdata;
   logic [1:0]  w_op_size;
   logic [IDX_W-1:0] w_idx;
   logic [31:0] w_rword, w_wlane, w_ldata;
   logic [3:0]  w_be;
   logic        w_align_err, w_range_err, w_err;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = w_idle && req_valid;
   // With zero wait the access completes on the acceptance edge, so it must see the live request.
   assign w_fire   = (w_accept && WAIT_CYCLES == 0) || (r_state == ST_WAIT && r_cnt == 4'd0);

   assign w_op_write    = w_idle ? req_write    : r_write;
   assign w_op_unsigned = w_idle ? req_unsigned : r_unsigned;
   assign w_op_addr     = w_idle ? req_addr     : r_addr;
   assign w_op_wdata    = w_idle ? req_wdata    : r_wdata;
   assign w_op_size     = w_idle ? req_size     : r_size;

   assign w_idx       = w_op_addr[IDX_W+1:2];
   assign w_rword     = r_mem[w_idx];
   assign w_range_err = ({2'b00, w_op_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign w_err       = w_align_err || w_range_err;

   load_store_align u_align (
      .i_size     (w_op_size),
      .i_addr_lo  (w_op_addr[1:0]),
      .i_wdata    (w_op_wdata),
      .i_rword    (w_rword),
      .i_unsigned (w_op_unsigned),
      .o_be       (w_be),
      .o_wlane    (w_wlane),
      .o_rdata    (w_ldata),
      .o_err      (w_align_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= 4'd0;
         r_write     <= 1'b0;
         r_unsigned  <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_size      <= 2'b00;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_cnt      <= CNT_INIT;
         end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_fire) begin
            r_rsp_rdata <= (w_op_write || w_err) ? 32'h0 : w_ldata;
            r_rsp_error <= w_err;
         end
      end
   end

   // Storage has no reset; gating on rst keeps a store from landing on a reset edge.
   always_ff @(posedge clk) begin
      if (w_fire && w_op_write && !w_err && !rst) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
   end

   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;

endmodule
